// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Sequential execute-stage ALU. Logic, arithmetic and compare operations finish
// in a single cycle; shifts move one bit position per cycle so no barrel
// shifter sits on the critical path. Operands are accepted through a
// valid/ready handshake and results leave through another, so either side of
// the pipeline may stall.
//
// Ports:
//   clk        in   1     system clock, all state on the rising edge
//   rst        in   1     asynchronous, active-high reset
//   in_valid   in   1     operands and op are valid
//   in_ready   out  1     unit can accept a new operation (state == IDLE)
//   alu_op     in   4     ALU control code
//   op_a       in   XLEN  operand A (rs1)
//   op_b       in   XLEN  operand B (rs2/imm); shift amount is op_b[SHW-1:0]
//   out_valid  out  1     result is valid (state == DONE)
//   out_ready  in   1     consumer accepts result
//   result     out  XLEN  result register (partial shift value while shifting)
//   zero       out  1     result == 0, decoded from the result register
// -----------------------------------------------------------------------------
module alu_exec_unit #(
   parameter int XLEN = 32,
   parameter int SHW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SLT  = 4'b1001;
   localparam logic [3:0] OP_SLTU = 4'b1010;

   localparam logic [XLEN-1:0] XLEN_ZERO = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] XLEN_ONE  = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [SHW-1:0]  CNT_ZERO  = {SHW{1'b0}};
   localparam logic [SHW-1:0]  CNT_ONE   = {{(SHW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SH_LEFT  = 2'd0,
      SH_RLOG  = 2'd1,
      SH_RARI  = 2'd2
   } shift_t;

   state_t          state_q, state_d;
   shift_t          shtype_q, shtype_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [SHW-1:0]  cnt_q, cnt_d;

   // Single-cycle datapath; unlisted codes fall back to ADD.
   function automatic logic [XLEN-1:0] alu_compute(
      input logic [3:0]      op,
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b
   );
      logic [XLEN-1:0] r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_SUB:  r = a - b;
         OP_SLT:  r = ($signed(a) < $signed(b)) ? XLEN_ONE : XLEN_ZERO;
         OP_SLTU: r = (a < b) ? XLEN_ONE : XLEN_ZERO;
         default: r = a + b;
      endcase
      return r;
   endfunction

   function automatic logic is_shift(input logic [3:0] op);
      logic s;
      case (op)
         OP_SLL, OP_SRL, OP_SRA: s = 1'b1;
         default:                s = 1'b0;
      endcase
      return s;
   endfunction

   function automatic shift_t shift_kind(input logic [3:0] op);
      shift_t k;
      case (op)
         OP_SRL:  k = SH_RLOG;
         OP_SRA:  k = SH_RARI;
         default: k = SH_LEFT;
      endcase
      return k;
   endfunction

   // One-bit shift step of the working register in the latched direction.
   function automatic logic [XLEN-1:0] shift_step(
      input shift_t          k,
      input logic [XLEN-1:0] v
   );
      logic [XLEN-1:0] r;
      case (k)
         SH_RLOG: r = {1'b0, v[XLEN-1:1]};
         SH_RARI: r = {v[XLEN-1], v[XLEN-1:1]};
         default: r = {v[XLEN-2:0], 1'b0};
      endcase
      return r;
   endfunction

   // Next-state and datapath update for the IDLE/SHIFT/DONE controller.
   always_comb begin
      state_d  = state_q;
      shtype_d = shtype_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (is_shift(alu_op)) begin
                  // The working register starts as op_a; a zero shift is
                  // already finished.
                  result_d = op_a;
                  if (op_b[SHW-1:0] == CNT_ZERO) begin
                     state_d = ST_DONE;
                  end else begin
                     cnt_d    = op_b[SHW-1:0];
                     shtype_d = shift_kind(alu_op);
                     state_d  = ST_SHIFT;
                  end
               end else begin
                  result_d = alu_compute(alu_op, op_a, op_b);
                  state_d  = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            result_d = shift_step(shtype_q, result_q);
            cnt_d    = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shtype_q <= SH_LEFT;
         result_q <= XLEN_ZERO;
         cnt_q    <= CNT_ZERO;
      end else begin
         state_q  <= state_d;
         shtype_q <= shtype_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
      end
   end

   // Handshake outputs are pure decodes of the state register.
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = (result_q == XLEN_ZERO);

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;

   int tests_run;
   int tests_failed;

   alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference behaviour straight from the operation table.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0110: return a - b;
         4'b0100: return a ^ b;
         4'b0101: return a << sh;
         4'b0111: return a >> sh;
         4'b1000: return $signed(a) >>> sh;
         4'b1001: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1010: return (a < b) ? 32'd1 : 32'd0;
         default: return a + b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
      if ((op == 4'b0101 || op == 4'b0111 || op == 4'b1000) && b[4:0] != 5'd0)
         return int'(b[4:0]) + 1;
      return 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one operation, wait for the result, apply 'hold' cycles of
   // backpressure, then complete the result handshake.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      logic [31:0] exp;
      int          lat;
      int          cycles;
      exp = ref_alu(op, a, b);
      lat = ref_latency(op, b);
      check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      alu_op   = op;
      op_a     = a;
      op_b     = b;
      @(posedge clk); #1;
      // Scramble operands after acceptance; the operation must not notice.
      in_valid = 1'b0;
      alu_op   = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
      cycles   = 1;
      while (out_valid !== 1'b1 && cycles < 40) begin
         op_a = $urandom;
         @(posedge clk); #1;
         cycles++;
      end
      check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".latency"}, cycles, lat);
      check({tag, ".result"}, result, exp);
      check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
         check({tag, ".hold_result"}, result, exp);
         check({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ".drop_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, ".idle_in_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [3:0] codes [16];
      tests_run    = 0;
      tests_failed = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      alu_op    = 4'd0;
      op_a      = 32'd0;
      op_b      = 32'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.in_ready", {31'd0, in_ready}, 32'd1);
      check("reset.out_valid", {31'd0, out_valid}, 32'd0);
      check("reset.result", result, 32'd0);
      check("reset.zero", {31'd0, zero}, 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // out_ready while idle does nothing.
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("idle_ready.out_valid", {31'd0, out_valid}, 32'd0);
      check("idle_ready.in_ready", {31'd0, in_ready}, 32'd1);

      // Directed cases.
      run_op("add",   4'b0010, 32'd5, 32'd7, 0);
      check("add.value", result, 32'd12);
      run_op("unk",   4'b1111, 32'd5, 32'd7, 0);
      check("unk.value", result, 32'd12);
      run_op("sub0",  4'b0110, 32'h0000_0010, 32'h0000_0010, 0);
      check("sub0.value", result, 32'd0);
      run_op("subm1", 4'b0110, 32'd0, 32'd1, 0);
      check("subm1.value", result, 32'hFFFF_FFFF);
      run_op("slt",   4'b1001, 32'hFFFF_FFFF, 32'd1, 0);
      check("slt.value", result, 32'd1);
      run_op("sltu",  4'b1010, 32'hFFFF_FFFF, 32'd1, 0);
      check("sltu.value", result, 32'd0);
      run_op("xor",   4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
      check("xor.value", result, 32'hFF00_FF00);
      run_op("or",    4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
      check("or.value", result, 32'hFFF0_FFF0);
      run_op("and",   4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
      check("and.value", result, 32'h00F0_00F0);
      run_op("sra4",  4'b1000, 32'h8000_0000, 32'h0000_0024, 0);
      check("sra4.value", result, 32'hF800_0000);
      run_op("srl4",  4'b0111, 32'h8000_0000, 32'h0000_0024, 0);
      check("srl4.value", result, 32'h0800_0000);
      run_op("sll31", 4'b0101, 32'd1, 32'd31, 0);
      check("sll31.value", result, 32'h8000_0000);
      run_op("sh0",   4'b0101, 32'h1234_5678, 32'hFFFF_FFE0, 0);
      check("sh0.value", result, 32'h1234_5678);
      run_op("bp",    4'b0010, 32'hDEAD_0000, 32'h0000_BEEF, 10);

      // Reset during SLL by 20, seven cycles after acceptance.
      in_valid = 1'b1;
      alu_op   = 4'b0101;
      op_a     = 32'h0000_0003;
      op_b     = 32'd20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) begin
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      check("abort.out_valid", {31'd0, out_valid}, 32'd0);
      check("abort.result", result, 32'd0);
      check("abort.zero", {31'd0, zero}, 32'd1);
      check("abort.in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op("post_abort_add", 4'b0010, 32'd2, 32'd3, 0);
      check("post_abort_add.value", result, 32'd5);

      // Randomized operations against the reference model.
      for (int i = 0; i < 16; i++) codes[i] = 4'(i);
      for (int i = 0; i < 60; i++) begin
         logic [3:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         op = codes[$urandom_range(0, 15)];
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         run_op($sformatf("rnd%0d", i), op, a, b, int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequential execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the selected operation on two XLEN-bit operands. Logic, arithmetic and compare operations complete in one cycle. Shifts iterate one bit position per cycle to keep the barrel shifter out of the critical path. Operands enter and results leave through valid/ready handshakes, so the pipeline can stall on either side.

## Interface
- XLEN, 32, operand/result width
- SHW, 5, shift-amount width (log2 XLEN)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and op are valid
- in_ready  out  1  unit can accept a new operation
- alu_op  in  4  ALU control code
- op_a  in  XLEN  operand A (rs1)
- op_b  in  XLEN  operand B (rs2 or immediate); shift amount is op_b[SHW-1:0]
- out_valid  out  1  result is valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0, derived combinationally from the result register

## Operation
- ALU control codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0100 XOR
  - 0101 SLL
  - 0111 SRL
  - 1000 SRA
  - 1001 SLT
  - 1010 SLTU
  - Any other code executes as ADD.
- Arithmetic:
  - ADD/SUB are modulo 2^XLEN; carry and overflow are discarded.
  - SLT compares signed; SLTU compares unsigned.
  - SLT/SLTU produce 1 or 0, zero-extended to XLEN.
  - SRA replicates bit XLEN-1 on every step.
  - Shift amount uses only op_b[SHW-1:0]; upper bits of op_b are ignored.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE:
    - in_ready=1.
    - On in_valid with a non-shift op: write the result register, go to DONE.
    - On a shift op with shamt==0: result=op_a, go to DONE.
    - On a shift op with shamt>0: load op_a into the working register, load the counter with shamt, latch the shift type, go to SHIFT.
  - SHIFT:
    - Each cycle, shift the working register one bit in the latched direction and decrement the counter.
    - The cycle the counter goes from 1 to 0, go to DONE.
    - in_ready=0.
  - DONE:
    - out_valid=1; result and zero are held stable.
    - On out_ready, go to IDLE.
    - in_ready=0.
- Inputs are sampled only at acceptance (in_valid && in_ready). Changes to alu_op/op_a/op_b afterwards do not affect the operation in flight.
- The working register doubles as the result register. result reflects the partial shift while in SHIFT; consumers must ignore it until out_valid.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - result=0
  - zero=1
  - counter=0
- Reset asserted mid-SHIFT or in DONE aborts the operation immediately (asynchronous). The pending result is lost.
- Latency, with acceptance at edge 0:
  - Non-shift ops and shamt==0: out_valid high after edge 1 (1 cycle).
  - Shift with shamt=n>0: out_valid high after edge n+1, so 32-bit worst case is 32 cycles.
- Backpressure: out_valid stays high and result/zero stay constant until the edge where out_ready=1. out_valid drops after that edge.
- out_ready asserted while out_valid=0 has no effect.
- in_ready rises the cycle after the result handshake. Minimum issue interval is 2 cycles for non-shift ops.
- in_valid asserted while in_ready=0 is ignored. The source must hold its request until a handshake.
- No combinational path from in_valid to out_valid. in_ready and out_valid depend only on state.

## Test plan
- Reset, then ADD op_a=5, op_b=7 -> out_valid one cycle after acceptance, result=12, zero=0. Unknown code 1111 with the same operands -> result=12.
- SUB 0x0000_0010 - 0x0000_0010 -> result=0, zero=1. SUB 0 - 1 -> result=0xFFFF_FFFF.
- SLT 0xFFFF_FFFF vs 1 -> result=1. SLTU with the same operands -> result=0. XOR/OR/AND of 0xF0F0_F0F0 and 0x0FF0_0FF0 -> 0xFF00_FF00 / 0xFFF0_FFF0 / 0x00F0_00F0.
- Shifts:
  - SRA 0x8000_0000 by op_b=0x24 (shamt 4) -> out_valid after 5 cycles, result=0xF800_0000.
  - SRL of the same -> 0x0800_0000.
  - SLL 1 by 31 -> 0x8000_0000 after 32 cycles.
  - shamt 0 -> result=op_a after 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles after a result -> out_valid, result and in_ready stay stable. Pulse out_ready -> IDLE next cycle. Change op_a during SHIFT -> result is unaffected.
- Assert rst during an SLL by 20 at step 7 -> immediately out_valid=0, result=0, zero=1, in_ready=1. A following ADD 2+3 returns 5.
